// File: rtl/conv_accum_engine.sv
// Time-multiplexed conv layer engine: accumulates KSIZE*KSIZE taps per output pixel,
// adds bias, optional ReLU, shift and requantise. Define CONV_SAT_EN for saturating requant.

module conv_accum_lane #(
  parameter int DATA_W = 16,
  parameter int W_W    = 16,
  parameter int IN_CH  = 4,
  parameter int ACC_W  = 48,
  parameter int BIAS_W = 32,
  parameter int SHIFT  = 19
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  input  logic                    load,
  input  logic                    relu_en,
  input  logic [IN_CH*DATA_W-1:0] data_in,
  input  logic [IN_CH*W_W-1:0]    weights,
  input  logic [BIAS_W-1:0]       bias,
  output logic [DATA_W-1:0]       data_out
`ifdef CONV_SAT_EN
  ,
  output logic                    sat
`endif
);
  localparam int PW = DATA_W + W_W + 1;

  logic signed [ACC_W-1:0] acc, tap_sum, r;
  logic signed [PW-1:0]    px, wx, pr;
  logic [DATA_W-1:0]       res;

  // Pixels are unsigned: zero-extend before the signed multiply.
  always_comb begin
    tap_sum = '0;
    px      = '0;
    wx      = '0;
    pr      = '0;
    for (int c = 0; c < IN_CH; c++) begin
      px      = {{(W_W+1){1'b0}}, data_in[c*DATA_W +: DATA_W]};
      wx      = {{(DATA_W+1){weights[c*W_W+W_W-1]}}, weights[c*W_W +: W_W]};
      pr      = px * wx;
      tap_sum = tap_sum + {{(ACC_W-PW){pr[PW-1]}}, pr};
    end
  end

  always_comb begin
    r = acc + {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    if (relu_en && r[ACC_W-1]) r = '0;
  end

`ifdef CONV_SAT_EN
  logic signed [ACC_W-1:0] sh;
  logic [ACC_W-DATA_W:0]   hi;
  logic                    ovf;
  assign sh  = r >>> SHIFT;
  assign hi  = sh[ACC_W-1:DATA_W-1];
  // Out of range whenever the bits above the output sign are not a pure sign extension.
  assign ovf = (|hi) & ~(&hi);
  assign sat = ovf;
  assign res = !ovf ? sh[DATA_W-1:0] :
               sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign res = DATA_W'(r >>> SHIFT);
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      data_out <= '0;
    end else begin
      if (acc_clr)     acc <= '0;
      else if (acc_en) acc <= acc + tap_sum;
      if (load) data_out <= res;
    end
  end
endmodule

module conv_accum_engine #(
  parameter int DATA_W = 16,
  parameter int W_W    = 16,
  parameter int IN_CH  = 4,
  parameter int OUT_CH = 8,
  parameter int KSIZE  = 5,
  parameter int ACC_W  = 48,
  parameter int BIAS_W = 32,
  parameter int SHIFT  = 19
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_CH*DATA_W-1:0]       data_in,
  input  logic [OUT_CH*IN_CH*W_W-1:0]   weights,
  input  logic                          bias_wr,
  input  logic [$clog2(OUT_CH)-1:0]     bias_addr,
  input  logic [BIAS_W-1:0]             bias_data,
  input  logic                          relu_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_CH*DATA_W-1:0]      data_out,
  output logic                          sat_flag
);
  localparam int TAPS = KSIZE * KSIZE;
  localparam int TC_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {ACCUM, FINAL, OUT} state_t;

  state_t                         state;
  logic [TC_W-1:0]                tap_cnt;
  logic [OUT_CH-1:0][BIAS_W-1:0]  bias_q;
  logic [DATA_W-1:0]              lane_q [OUT_CH];
  logic                           acc_en, acc_clr, load;

  assign in_ready = rst_n & (state == ACCUM);
  assign acc_en   = in_valid & in_ready & ~clear;
  assign acc_clr  = clear | (state == FINAL);
  assign load     = (state == FINAL) & ~clear;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      tap_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      tap_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: if (in_valid) begin
          if (tap_cnt == TC_W'(TAPS-1)) begin
            tap_cnt <= '0;
            state   <= FINAL;
          end else begin
            tap_cnt <= tap_cnt + TC_W'(1);
          end
        end
        FINAL: begin
          state     <= OUT;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // FINAL reads bias_q before this edge, so a same-cycle write lands on the next pixel.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)       bias_q            <= '0;
    else if (bias_wr) bias_q[bias_addr] <= bias_data;
  end

`ifdef CONV_SAT_EN
  logic sat_vec [OUT_CH];
  logic sat_any;
  always_comb begin
    sat_any = 1'b0;
    for (int o = 0; o < OUT_CH; o++) sat_any = sat_any | sat_vec[o];
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                sat_flag <= 1'b0;
    else if (load && sat_any)  sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

  for (genvar o = 0; o < OUT_CH; o++) begin : g_lane
    conv_accum_lane #(
      .DATA_W(DATA_W), .W_W(W_W), .IN_CH(IN_CH),
      .ACC_W(ACC_W), .BIAS_W(BIAS_W), .SHIFT(SHIFT)
    ) u_lane (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .acc_en   (acc_en),
      .acc_clr  (acc_clr),
      .load     (load),
      .relu_en  (relu_en),
      .data_in  (data_in),
      .weights  (weights[o*IN_CH*W_W +: IN_CH*W_W]),
      .bias     (bias_q[o]),
      .data_out (lane_q[o])
`ifdef CONV_SAT_EN
      ,
      .sat      (sat_vec[o])
`endif
    );
  end

  always_comb begin
    data_out = '0;
    for (int o = 0; o < OUT_CH; o++) data_out[o*DATA_W +: DATA_W] = lane_q[o];
  end
endmodule

// File: tb/tb_conv_accum_engine.sv
// Directed + randomized bench for conv_accum_engine (KSIZE=3, SHIFT=0) with an
// arithmetic reference model; honours CONV_SAT_EN for the requant rule.

module tb_conv_accum_engine;
  localparam int DW = 16, WW = 16, IC = 4, OC = 8, KS = 3, AW = 48, BW = 32, SH = 0;
  localparam int TAPS = KS * KS;

  logic              clk_in = 1'b0;
  logic              rst_n, clear, in_valid, in_ready, bias_wr, relu_en;
  logic              out_valid, out_ready, sat_flag;
  logic [IC*DW-1:0]  data_in;
  logic [OC*IC*WW-1:0] weights;
  logic [2:0]        bias_addr;
  logic [BW-1:0]     bias_data;
  logic [OC*DW-1:0]  data_out;

  int     checks = 0, errors = 0;
  longint macc  [OC];
  longint mbias [OC];
  logic [15:0] mexp [OC];
  logic   msat;

  always #5 clk_in = ~clk_in;

  conv_accum_engine #(
    .DATA_W(DW), .W_W(WW), .IN_CH(IC), .OUT_CH(OC), .KSIZE(KS),
    .ACC_W(AW), .BIAS_W(BW), .SHIFT(SH)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .data_in(data_in), .weights(weights),
    .bias_wr(bias_wr), .bias_addr(bias_addr), .bias_data(bias_data),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sat_flag(sat_flag)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pick_d(input int kind);
    case (kind)
      0:       return 16'd2;
      2:       return 16'hFFFF;
      3:       return 16'($urandom_range(0, 300));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] pick_w(input int kind);
    int v;
    case (kind)
      0:       return 16'd3;
      2:       return 16'h7FFF;
      3: begin v = int'($urandom_range(0, 200)) - 100; return v[15:0]; end
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [127:0] exp_packed();
    logic [127:0] p = '0;
    for (int o = 0; o < OC; o++) p[o*DW +: DW] = mexp[o];
    return p;
  endfunction

  // Reference: pixel = sum of taps + bias, ReLU, shift, then truncate or clamp.
  task automatic model_final(input logic relu);
    longint r;
    for (int o = 0; o < OC; o++) begin
      r = macc[o] + mbias[o];
      if (relu && r < 0) r = 0;
      r = r >>> SH;
`ifdef CONV_SAT_EN
      if (r > 32767)       begin mexp[o] = 16'h7FFF; msat = 1'b1; end
      else if (r < -32768) begin mexp[o] = 16'h8000; msat = 1'b1; end
      else                 mexp[o] = r[15:0];
`else
      mexp[o] = r[15:0];
`endif
      macc[o] = 0;
    end
  endtask

  task automatic wr_bias(input int a, input longint v);
    @(negedge clk_in);
    bias_wr = 1'b1; bias_addr = 3'(a); bias_data = 32'(v);
    @(posedge clk_in);
    #1 bias_wr = 1'b0;
    mbias[a] = v;
  endtask

  task automatic feed_beats(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      check("in_ready_accum", in_ready, 1);
      for (int c = 0; c < IC; c++) data_in[c*DW +: DW] = pick_d(kind);
      for (int k = 0; k < OC*IC; k++) weights[k*WW +: WW] = pick_w(kind);
      in_valid = 1'b1;
      relu_en  = 1'($urandom_range(0, 1));
      @(posedge clk_in);
      for (int o = 0; o < OC; o++)
        for (int c = 0; c < IC; c++)
          macc[o] += longint'(data_in[c*DW +: DW]) * longint'($signed(weights[(o*IC+c)*WW +: WW]));
    end
  endtask

  task automatic finish_pixel(input logic relu, input int hold, input bit fin_wr, input bit clr_out);
    logic [127:0] ep;
    @(negedge clk_in);
    in_valid = 1'b0;
    relu_en  = relu;
    check("in_ready_final", in_ready, 0);
    check("out_valid_final", out_valid, 0);
    if (fin_wr) begin bias_wr = 1'b1; bias_addr = 3'd2; bias_data = 32'd1000; end
    model_final(relu);
    ep = exp_packed();
    @(negedge clk_in);
    relu_en = ~relu;
    if (fin_wr) begin bias_wr = 1'b0; mbias[2] = 1000; end
    check("out_valid_rise", out_valid, 1);
    check("in_ready_out", in_ready, 0);
    for (int o = 0; o < OC; o++)
      check($sformatf("data_out_ch%0d", o), data_out[o*DW +: DW], mexp[o]);
    check("sat_flag", sat_flag, msat);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      data_in  = {IC{16'h1234}};
      @(negedge clk_in);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_data_out", data_out, ep);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear     = clr_out;
    @(negedge clk_in);
    out_ready = 1'b0;
    clear     = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    if (clr_out) check("clear_keeps_data", data_out, ep);
  endtask

  task automatic run_pixel(input int kind, input logic relu, input int hold, input bit fin_wr, input bit clr_out);
    feed_beats(kind, TAPS);
    finish_pixel(relu, hold, fin_wr, clr_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; bias_wr = 1'b0; relu_en = 1'b0;
    out_ready = 1'b0; data_in = '0; weights = '0; bias_addr = '0; bias_data = '0;
    msat = 1'b0;
    for (int o = 0; o < OC; o++) begin macc[o] = 0; mbias[o] = 0; mexp[o] = '0; end

    repeat (2) @(negedge clk_in);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_sat_flag", sat_flag, 0);
    rst_n = 1'b1;

    // basic 216 per channel
    run_pixel(0, 1'b1, 0, 1'b0, 1'b0);
    // bias -300 on ch1 with ReLU, bias write to ch2 during FINAL
    wr_bias(1, -300);
    run_pixel(0, 1'b1, 0, 1'b1, 1'b0);
    // ReLU off: ch1 = -84, ch2 now picks up 1000
    run_pixel(0, 1'b0, 0, 1'b0, 1'b0);
    // backpressure, then a clean next pixel
    run_pixel(0, 1'b1, 5, 1'b0, 1'b0);
    run_pixel(0, 1'b1, 0, 1'b0, 1'b0);
    // saturation corner
    run_pixel(2, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      for (int o = 0; o < OC; o++) wr_bias(o, longint'(int'($urandom_range(0, 200000)) - 100000));
      run_pixel((i % 2) ? 1 : 3, 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
    end

    // reset in the middle of a pixel
    feed_beats(1, 4);
    @(negedge clk_in);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_sat_flag", sat_flag, 0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    msat  = 1'b0;
    for (int o = 0; o < OC; o++) begin macc[o] = 0; mbias[o] = 0; end
    wr_bias(1, -300);
    run_pixel(0, 1'b1, 0, 1'b0, 1'b0);

    // clear after 5 beats, colliding with an input handshake
    feed_beats(1, 5);
    @(negedge clk_in);
    clear    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk_in);
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int o = 0; o < OC; o++) macc[o] = 0;
    check("clr_in_ready", in_ready, 1);
    check("clr_out_valid", out_valid, 0);
    run_pixel(0, 1'b0, 0, 1'b0, 1'b0);

    // clear together with out_ready in OUT
    run_pixel(3, 1'b0, 0, 1'b0, 1'b1);
    run_pixel(0, 1'b1, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
